// File: rtl/instr_encoder_stream.sv
// instr_encoder_stream
// Turns a stream of symbolic instruction requests into RV64I machine words.
// Each request is accepted with a valid/ready handshake and encoded into a
// registered output stage with one cycle of latency. The LI pseudo-op expands
// into ADDI, into LUI alone, or into LUI followed by ADDIW. The expansion
// depends on the immediate value.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   req_valid_i    request valid
//   req_ready_o    request accepted when valid && ready at an edge
//   req_op_i       operation code (0..13 legal, 14/15 illegal)
//   req_rd_i       destination register
//   req_rs1_i      source register 1
//   req_rs2_i      source register 2
//   req_imm_i      signed immediate (LUI/AUIPC take bits [19:0])
//   instr_valid_o  encoded word valid
//   instr_ready_i  downstream accepts the word
//   instr_o        encoded instruction word
//   illegal_o      one-cycle pulse after an illegal op is consumed
//   instr_count_o  number of words handed off (wraps)
module instr_encoder_stream #(
   parameter int unsigned CntWidth = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [3:0]          req_op_i,
   input  logic [4:0]          req_rd_i,
   input  logic [4:0]          req_rs1_i,
   input  logic [4:0]          req_rs2_i,
   input  logic [31:0]         req_imm_i,
   output logic                instr_valid_o,
   input  logic                instr_ready_i,
   output logic [31:0]         instr_o,
   output logic                illegal_o,
   output logic [CntWidth-1:0] instr_count_o
);

   localparam logic [3:0] OpNop   = 4'd0;
   localparam logic [3:0] OpAdd   = 4'd1;
   localparam logic [3:0] OpSub   = 4'd2;
   localparam logic [3:0] OpAddi  = 4'd3;
   localparam logic [3:0] OpLui   = 4'd4;
   localparam logic [3:0] OpAuipc = 4'd5;
   localparam logic [3:0] OpJal   = 4'd6;
   localparam logic [3:0] OpBeq   = 4'd7;
   localparam logic [3:0] OpBne   = 4'd8;
   localparam logic [3:0] OpLw    = 4'd9;
   localparam logic [3:0] OpSw    = 4'd10;
   localparam logic [3:0] OpLi    = 4'd11;
   localparam logic [3:0] OpEcall = 4'd12;
   localparam logic [3:0] OpMret  = 4'd13;

   localparam logic [31:0] WordNop = 32'h0000_0013;

   typedef enum logic [0:0] {StIdle, StEmitLo} state_e;

   state_e                state_q, state_d;
   logic [31:0]           instr_q, instr_d;
   logic                  valid_q, valid_d;
   logic                  illegal_q, illegal_d;
   logic [CntWidth-1:0]   count_q, count_d;
   logic [4:0]            lo_rd_q, lo_rd_d;
   logic [11:0]           lo_imm_q, lo_imm_d;

   logic        stage_free;
   logic        handoff;
   logic        accept;
   logic [31:0] enc_word;
   logic        enc_illegal;
   logic        li_small;
   logic        li_split;
   logic [19:0] li_hi;
   logic [11:0] li_lo;
   logic [31:0] li_sum;

   assign stage_free  = !valid_q || instr_ready_i;
   assign handoff     = valid_q && instr_ready_i;
   assign req_ready_o = !rst_i && (state_q == StIdle) && stage_free;
   assign accept      = req_valid_i && req_ready_o;

   // Immediate fits a 12-bit signed field when bits [31:11] are all equal.
   assign li_small = (req_imm_i[31:11] == '0) || (req_imm_i[31:11] == '1);
   // Rounding by 0x800 compensates for ADDIW sign-extending the low part.
   assign li_sum   = req_imm_i + 32'h0000_0800;
   assign li_hi    = li_sum[31:12];
   assign li_lo    = req_imm_i[11:0];
   assign li_split = !li_small && (li_lo != 12'h000);

   // Encoder for the first (or only) word of a request.
   always_comb begin
      enc_word    = WordNop;
      enc_illegal = 1'b0;
      case (req_op_i)
         OpNop:   enc_word = WordNop;
         OpAdd:   enc_word = {7'h00, req_rs2_i, req_rs1_i, 3'b000, req_rd_i, 7'h33};
         OpSub:   enc_word = {7'h20, req_rs2_i, req_rs1_i, 3'b000, req_rd_i, 7'h33};
         OpAddi:  enc_word = {req_imm_i[11:0], req_rs1_i, 3'b000, req_rd_i, 7'h13};
         OpLui:   enc_word = {req_imm_i[19:0], req_rd_i, 7'h37};
         OpAuipc: enc_word = {req_imm_i[19:0], req_rd_i, 7'h17};
         OpJal:   enc_word = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11],
                              req_imm_i[19:12], req_rd_i, 7'h6f};
         OpBeq, OpBne: begin
            enc_word = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i,
                        2'b00, (req_op_i == OpBne), req_imm_i[4:1], req_imm_i[11], 7'h63};
         end
         OpLw:    enc_word = {req_imm_i[11:0], req_rs1_i, 3'b010, req_rd_i, 7'h03};
         OpSw:    enc_word = {req_imm_i[11:5], req_rs2_i, req_rs1_i, 3'b010,
                              req_imm_i[4:0], 7'h23};
         OpLi: begin
            if (li_small) begin
               enc_word = {req_imm_i[11:0], 5'd0, 3'b000, req_rd_i, 7'h13};
            end else begin
               enc_word = {li_hi, req_rd_i, 7'h37};
            end
         end
         OpEcall: enc_word = 32'h0000_0073;
         OpMret:  enc_word = 32'h3020_0073;
         default: enc_illegal = 1'b1;
      endcase
   end

   // Next-state for FSM, output stage and counter.
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      valid_d   = valid_q;
      illegal_d = 1'b0;
      count_d   = count_q;
      lo_rd_d   = lo_rd_q;
      lo_imm_d  = lo_imm_q;

      if (handoff) begin
         valid_d = 1'b0;
         count_d = count_q + CntWidth'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (enc_illegal) begin
                  illegal_d = 1'b1;
               end else begin
                  instr_d = enc_word;
                  valid_d = 1'b1;
                  if ((req_op_i == OpLi) && li_split) begin
                     state_d  = StEmitLo;
                     lo_rd_d  = req_rd_i;
                     lo_imm_d = li_lo;
                  end
               end
            end
         end
         StEmitLo: begin
            // ADDIW loads on the same edge the LUI leaves the stage.
            if (stage_free) begin
               instr_d = {lo_imm_q, lo_rd_q, 3'b000, lo_rd_q, 7'h1b};
               valid_d = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         instr_q   <= WordNop;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         count_q   <= '0;
         lo_rd_q   <= 5'd0;
         lo_imm_q  <= 12'd0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
         count_q   <= count_d;
         lo_rd_q   <= lo_rd_d;
         lo_imm_q  <= lo_imm_d;
      end
   end

   assign instr_o       = instr_q;
   assign instr_valid_o = valid_q;
   assign illegal_o     = illegal_q;
   assign instr_count_o = count_q;

endmodule

// File: tb/tb_instr_encoder_stream.sv
// Scoreboard bench for instr_encoder_stream: the driver pushes expected words
// from a field-arithmetic reference model, a negedge monitor pops and compares.
module tb_instr_encoder_stream;

   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic [3:0]    req_op_i = '0;
   logic [4:0]    req_rd_i = '0;
   logic [4:0]    req_rs1_i = '0;
   logic [4:0]    req_rs2_i = '0;
   logic [31:0]   req_imm_i = '0;
   logic          instr_valid_o;
   logic          instr_ready_i = 1'b1;
   logic [31:0]   instr_o;
   logic          illegal_o;
   logic [CW-1:0] instr_count_o;

   always #5 clk = ~clk;

   instr_encoder_stream #(.CntWidth(CW)) dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_op_i      (req_op_i),
      .req_rd_i      (req_rd_i),
      .req_rs1_i     (req_rs1_i),
      .req_rs2_i     (req_rs2_i),
      .req_imm_i     (req_imm_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_o       (instr_o),
      .illegal_o     (illegal_o),
      .instr_count_o (instr_count_o)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q[$];
   int          exp_ill = 0;
   int          model_cnt = 0;
   int          rdy_mode = 0;  // 0 always ready, 1 random, 2 never ready

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: returns number of words (0 = illegal).
   function automatic int encode(input logic [3:0] op, input logic [4:0] rd5,
                                 input logic [4:0] rs1_5, input logic [4:0] rs2_5,
                                 input logic [31:0] u,
                                 output logic [31:0] w0, output logic [31:0] w1);
      logic [31:0] rd, rs1, rs2, hi, lo;
      int          s;
      rd = 32'(rd5); rs1 = 32'(rs1_5); rs2 = 32'(rs2_5);
      w0 = 0; w1 = 0;
      encode = 1;
      case (op)
         0:  w0 = 32'h13;
         1:  w0 = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
         2:  w0 = 32'h4000_0000 | (rs2 << 20) | (rs1 << 15) | (rd << 7) | 32'h33;
         3:  w0 = ((u & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h13;
         4:  w0 = ((u & 32'hFFFFF) << 12) | (rd << 7) | 32'h37;
         5:  w0 = ((u & 32'hFFFFF) << 12) | (rd << 7) | 32'h17;
         6:  w0 = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) |
                  (((u >> 11) & 1) << 20) | (((u >> 12) & 255) << 12) | (rd << 7) | 32'h6F;
         7, 8: w0 = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) |
                    (rs1 << 15) | (32'(op - 4'd7) << 12) | (((u >> 1) & 15) << 8) |
                    (((u >> 11) & 1) << 7) | 32'h63;
         9:  w0 = ((u & 32'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 32'h03;
         10: w0 = (((u >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12) |
                  ((u & 31) << 7) | 32'h23;
         11: begin
            s = $signed(u);
            if (s >= -2048 && s <= 2047) begin
               w0 = ((u & 32'hFFF) << 20) | (rd << 7) | 32'h13;
            end else begin
               hi = ((u + 32'h800) >> 12) & 32'hFFFFF;
               lo = u & 32'hFFF;
               w0 = (hi << 12) | (rd << 7) | 32'h37;
               if (lo != 0) begin
                  w1 = (lo << 20) | (rd << 15) | (rd << 7) | 32'h1B;
                  encode = 2;
               end
            end
         end
         12: w0 = 32'h0000_0073;
         13: w0 = 32'h3020_0073;
         default: encode = 0;
      endcase
   endfunction

   // Issues one request, pushes its expectation and checks 1-cycle latency.
   task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
      int          n;
      logic [31:0] w0, w1;
      bit          ok;
      ok = 0;
      n = encode(op, rd, rs1, rs2, imm, w0, w1);
      req_op_i = op; req_rd_i = rd; req_rs1_i = rs1; req_rs2_i = rs2; req_imm_i = imm;
      req_valid_i = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (req_ready_o) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++; n_err++;
         $display("FAIL send_timeout: req_ready_o stayed 0, required 1 within 100 cycles");
         @(posedge clk); #1;
         req_valid_i = 1'b0;
      end else begin
         if (n == 0) exp_ill++;
         else begin
            exp_q.push_back(w0);
            if (n == 2) exp_q.push_back(w1);
         end
         @(posedge clk); #1;
         req_valid_i = 1'b0;
         if (n == 0) check("illegal_pulse", 32'(illegal_o), 32'd1);
         else begin
            check("latency_valid", 32'(instr_valid_o), 32'd1);
            check("latency_word", instr_o, w0);
         end
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_i = 1'b1; req_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      exp_q.delete(); exp_ill = 0; model_cnt = 0;
      check("rst_valid", 32'(instr_valid_o), 32'd0);
      check("rst_word", instr_o, 32'h13);
      check("rst_count", 32'(instr_count_o), 32'd0);
      check("rst_illegal", 32'(illegal_o), 32'd0);
      rst_i = 1'b0;
   endtask

   task automatic drain();
      rdy_mode = 0; instr_ready_i = 1'b1;
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      @(posedge clk); #1;
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_illegal", 32'(exp_ill), 32'd0);
   endtask

   // Ready driver.
   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       instr_ready_i = 1'b1;
            1:       instr_ready_i = 1'($urandom_range(0, 1));
            default: instr_ready_i = 1'b0;
         endcase
      end
   end

   // Monitor / scoreboard.
   logic        hold_pending = 1'b0;
   logic [31:0] held = '0;
   always @(negedge clk) begin
      if (rst_i) begin
         hold_pending = 1'b0;
         check("ready_in_reset", 32'(req_ready_o), 32'd0);
      end else begin
         if (hold_pending) begin
            check("hold_valid", 32'(instr_valid_o), 32'd1);
            check("hold_word", instr_o, held);
         end
         hold_pending = instr_valid_o && !instr_ready_i;
         held = instr_o;
         if (instr_valid_o && instr_ready_i) begin
            check("count", 32'(instr_count_o), 32'(model_cnt % (1 << CW)));
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_word: got %h expected no word at %0t", instr_o, $time);
            end else begin
               check("word", instr_o, exp_q.pop_front());
            end
            model_cnt++;
         end
         if (illegal_o) begin
            n_cmp++;
            if (exp_ill > 0) exp_ill--;
            else begin
               n_err++;
               $display("FAIL unexpected_illegal: got illegal_o=1 expected 0 at %0t", $time);
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] imm;
      logic [31:0] edges [8];
      edges = '{32'hFFFF_F800, 32'h0000_07FF, 32'hFFFF_F7FF, 32'h0000_0800,
                32'h7FFF_F800, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_F000};

      do_reset();

      // ADDI x1, x0, 5
      send(4'd3, 5'd1, 5'd0, 5'd0, 32'd5);
      check("addi_word", instr_o, 32'h0050_0093);
      @(posedge clk); #1;
      check("addi_count", 32'(instr_count_o), 32'd1);

      // LI splits into LUI + ADDIW
      send(4'd11, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
      check("li_lui", instr_o, 32'h1234_52B7);
      check("li_ready_emitlo", 32'(req_ready_o), 32'd0);
      @(posedge clk); #1;
      check("li_addiw", instr_o, 32'h6782_829B);
      check("li_addiw_valid", 32'(instr_valid_o), 32'd1);

      send(4'd11, 5'd5, 5'd0, 5'd0, 32'h0000_0800);
      check("li800_lui", instr_o, 32'h0000_12B7);
      @(posedge clk); #1;
      check("li800_addiw", instr_o, 32'h8002_829B);

      send(4'd11, 5'd5, 5'd0, 5'd0, 32'h0001_0000);
      check("li_lui_only", instr_o, 32'h0001_02B7);
      @(posedge clk); #1;
      check("li_lui_only_done", 32'(instr_valid_o), 32'd0);

      // ECALL stalled 3 cycles, then MRET
      rdy_mode = 2; instr_ready_i = 1'b0;
      send(4'd12, 5'd0, 5'd0, 5'd0, 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         check("ecall_hold", instr_o, 32'h0000_0073);
         check("ecall_hold_valid", 32'(instr_valid_o), 32'd1);
      end
      rdy_mode = 0; instr_ready_i = 1'b1;
      send(4'd13, 5'd0, 5'd0, 5'd0, 32'd0);
      check("mret_word", instr_o, 32'h3020_0073);

      // Illegal op
      send(4'd15, 5'd3, 5'd4, 5'd5, 32'h1234);
      check("illegal_no_word", 32'(instr_valid_o), 32'd0);
      @(posedge clk); #1;
      check("illegal_one_cycle", 32'(illegal_o), 32'd0);
      drain();

      // Reset during EMIT_LO discards the pending ADDIW
      rdy_mode = 2; instr_ready_i = 1'b0;
      send(4'd11, 5'd5, 5'd0, 5'd0, 32'h1234_5678);
      do_reset();
      rdy_mode = 0; instr_ready_i = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("no_addiw_after_rst", 32'(instr_valid_o), 32'd0);

      // Randomized traffic against the model
      rdy_mode = 1;
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         op = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) op = 4'd11;
         case ($urandom_range(0, 3))
            0:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1:       imm = $urandom;
            2:       imm = $urandom & 32'hFFFF_F000;
            default: imm = edges[$urandom_range(0, 7)];
         endcase
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         send(op, 5'($urandom), 5'($urandom), 5'($urandom), imm);
      end
      drain();

      // Counter wrap after 2^CW handoffs
      do_reset();
      for (int i = 0; i < (1 << CW); i++) send(4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      drain();
      check("count_wrap", 32'(instr_count_o), 32'd0);
      check("model_wrap", 32'(model_cnt), 32'(1 << CW));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/instr_encoder_stream.md
INSTR_ENCODER_STREAM -- requirements
Module: instr_encoder_stream

Interface
REQ-001 SHALL have parameter CntWidth, default 16, width of the emitted-word counter.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_i, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port req_valid_i, input, 1, request valid.
REQ-005 SHALL have port req_ready_o, output, 1, request accepted when req_valid_i && req_ready_o at a clock edge.
REQ-006 SHALL have port req_op_i, input, 4, operation: 0 NOP, 1 ADD, 2 SUB, 3 ADDI, 4 LUI, 5 AUIPC, 6 JAL, 7 BEQ, 8 BNE, 9 LW, 10 SW, 11 LI (pseudo), 12 ECALL, 13 MRET; 14-15 illegal.
REQ-007 SHALL have ports req_rd_i, req_rs1_i and req_rs2_i, input, 5 each, register indices.
REQ-008 SHALL have port req_imm_i, input, 32, signed immediate; LUI/AUIPC use bits [19:0] as the upper-immediate field.
REQ-009 SHALL have port instr_valid_o, output, 1, encoded word valid.
REQ-010 SHALL have port instr_ready_i, input, 1, downstream accepts the word.
REQ-011 SHALL have port instr_o, output, 32, RV64 instruction word.
REQ-012 SHALL have port illegal_o, output, 1, one-cycle pulse when an illegal op is consumed.
REQ-013 SHALL have port instr_count_o, output, CntWidth, number of words handed off.

Function
REQ-014 SHALL encode with standard RV64I formats: ADD/SUB R-type (opcode 0x33, funct7 0x00/0x20), ADDI I-type (0x13), LUI (0x37), AUIPC (0x17), JAL J-type (0x6F), BEQ/BNE B-type (0x63, funct3 0/1), LW I-type (0x03, funct3 2), SW S-type (0x23, funct3 2), ECALL 0x00000073, MRET 0x30200073, NOP 0x00000013.
REQ-015 SHALL truncate immediates to each format's field; imm[0] is dropped for B/J types; fields not used by a format are ignored.
REQ-016 SHALL use a registered output stage: a word accepted at edge N is presented on instr_o with instr_valid_o=1 from cycle N+1 (1-cycle latency).
REQ-017 SHALL hold instr_o and instr_valid_o stable while instr_valid_o && !instr_ready_i.
REQ-018 SHALL drive req_ready_o = (state==IDLE) && (!instr_valid_o || instr_ready_i), combinationally.
REQ-019 SHALL sustain one word per cycle when instr_ready_i is held high.
REQ-020 SHALL use FSM states IDLE and EMIT_LO; only LI leaves IDLE.
REQ-021 LI with imm in [-2048, 2047] SHALL emit a single ADDI rd, x0, imm and stay in IDLE.
REQ-022 Any other LI SHALL compute hi = (imm + 0x800) >> 12 (20 bits, wrap mod 2^32) and lo = imm[11:0].
REQ-023 That LI SHALL emit LUI rd, hi.
REQ-024 If lo != 0, that LI SHALL then go to EMIT_LO, store rd and lo, and emit ADDIW rd, rd, lo (opcode 0x1B) once the LUI is handed off; the state then returns to IDLE.
REQ-025 If lo == 0, that LI SHALL emit LUI only.
REQ-026 An illegal op SHALL be accepted, emit no word and pulse illegal_o for the cycle after acceptance, with the output stage unchanged.
REQ-027 instr_count_o SHALL increment on each instr_valid_o && instr_ready_i edge and wrap from 2^CntWidth-1 to 0.
REQ-028 A handoff and a new acceptance on the same edge SHALL load the new word with no bubble.

Reset
REQ-029 On rst_i=1 at an edge, the block SHALL set state=IDLE, instr_valid_o=0, instr_o=0x00000013, illegal_o=0 and instr_count_o=0.
REQ-030 Reset SHALL take priority over all handshakes; a pending LI second half or an unaccepted word is discarded.
REQ-031 req_ready_o SHALL be 0 while rst_i=1.

Verification
REQ-032 ADDI rd=1, rs1=0, imm=5 with ready high SHALL give instr_o=0x00500093 one cycle later and instr_count_o=1.
REQ-033 LI rd=5, imm=0x12345678 SHALL emit 0x123452B7 then 0x6782829B on consecutive cycles and hold req_ready_o=0 during EMIT_LO.
REQ-034 LI rd=5, imm=0x00000800 SHALL emit 0x000012B7 then 0x8002829B.
REQ-035 LI rd=5, imm=0x00010000 SHALL emit the single word 0x000102B7.
REQ-036 ECALL with instr_ready_i=0 for 3 cycles SHALL hold 0x00000073 stable, then hand off on the first ready cycle; a following MRET SHALL emit 0x30200073.
REQ-037 An op=15 request SHALL pulse illegal_o once with no instr_valid_o.
REQ-038 rst_i asserted during EMIT_LO SHALL clear instr_valid_o and emit no ADDIW.
REQ-039 2^CntWidth handoffs SHALL wrap instr_count_o to 0.
